// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch FSM state type for the MIPS fetch block
//
// Contents:
//   XLEN          - datapath / address width
//   PC_INC        - sequential fetch increment (one 32-bit word)
//   fetch_state_t - fetch FSM states; S_ERROR exists only when
//                   MIPS_FETCH_ALIGN_CHECK_EN is defined
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        ,
        S_ERROR = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - single-outstanding-request MIPS instruction fetch stage
//
// Optional feature macro: MIPS_FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect target enters a sticky ERROR state and
//               raises fetch_err until reset
//   undefined : redirect_pc[1:0] is ignored (forced to 2'b00), no fetch_err
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   stall        in   decode cannot accept the presented instruction
//   redirect     in   branch/jump taken strobe (priority over stall)
//   redirect_pc  in   branch/jump target
//   imem_req     out  instruction memory read request
//   imem_addr    out  word address of the request
//   imem_ack     in   memory completion strobe (may coincide with imem_req)
//   imem_rdata   in   read data, valid with imem_ack
//   instr_valid  out  instr/pc_out hold a deliverable instruction
//   instr        out  fetched instruction word
//   pc_out       out  address of instr
//   pc_plus4     out  pc_out + 4 (wrapping), combinational
//   fetch_err    out  sticky misaligned-target flag (macro only)
module mips_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_err
`endif
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [XLEN-1:0] r_req_addr, w_req_addr_nxt;
    logic [XLEN-1:0] r_pc_out, w_pc_out_nxt;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic            r_instr_valid, w_instr_valid_nxt;
    logic            r_discard, w_discard_nxt;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect_en;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    logic            r_fetch_err, w_fetch_err_nxt;
    logic            w_misaligned;

    assign w_redirect_pc = redirect_pc;
    assign w_misaligned  = |redirect_pc[1:0];
    // ERROR is terminal until reset, so redirects are ignored there.
    assign w_redirect_en = redirect && (r_state != S_ERROR);
    assign fetch_err     = r_fetch_err;
`else
    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
    assign w_redirect_en = redirect;
`endif

    assign imem_req    = (r_state == S_REQ) && !rst;
    // While a redirected request is still outstanding, r_fetch_pc already
    // holds the new target; the bus must keep showing the old address.
    assign imem_addr   = r_discard ? r_req_addr : r_fetch_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_out + PC_INC;

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_req_addr_nxt    = r_req_addr;
        w_pc_out_nxt      = r_pc_out;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_discard_nxt     = r_discard;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        w_fetch_err_nxt   = r_fetch_err;
`endif

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (r_discard) begin
                        // Response to a pre-redirect request: drop it and
                        // issue the redirected fetch next cycle.
                        w_discard_nxt = 1'b0;
                    end else if (!w_redirect_en) begin
                        w_instr_nxt       = imem_rdata;
                        w_pc_out_nxt      = r_fetch_pc;
                        w_instr_valid_nxt = 1'b1;
                        w_fetch_pc_nxt    = r_fetch_pc + PC_INC;
                        w_state_nxt       = S_VALID;
                    end
                end else if (w_redirect_en && !r_discard) begin
                    // Only the first redirect captures the bus address; a
                    // later one just retargets r_fetch_pc below.
                    w_discard_nxt  = 1'b1;
                    w_req_addr_nxt = r_fetch_pc;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_REQ;
                end
            end
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_redirect_en) begin
            w_fetch_pc_nxt    = w_redirect_pc;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_REQ;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
            if (w_misaligned) begin
                w_state_nxt     = S_ERROR;
                w_fetch_err_nxt = 1'b1;
                w_discard_nxt   = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_pc_out      <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_discard     <= w_discard_nxt;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
            r_fetch_err   <= w_fetch_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mips_fetch.sv
// tb/tb_mips_fetch.sv - scoreboard testbench for mips_fetch
module tb_mips_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int n_checks   = 0;
    int n_errors   = 0;
    int ack_min    = 0;
    int ack_max    = 0;
    int deliveries = 0;
    logic [31:0] exp_q[$];

    mips_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_err   (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0040_0010) return 32'h2008_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected delivery stream: from a start address, consecutive words.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int k = 0; k < 256; k++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) exp_q.delete();
        else load_stream(tgt);
`else
        load_stream(tgt & 32'hFFFF_FFFC);
`endif
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        load_stream(RESET_PC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!instr_valid && k < maxc);
        chk(nm, {31'd0, instr_valid}, 32'd1);
    endtask

    // Memory responder: random latency per request, data derived from address.
    initial begin
        int          wait_cnt;
        logic        busy;
        logic [31:0] held;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        busy       = 1'b0;
        wait_cnt   = 0;
        held       = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    held     = imem_addr;
                    wait_cnt = int'($urandom_range(ack_max, ack_min));
                end else begin
                    chk("addr_hold", imem_addr, held);
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_fn(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt--;
                end
            end else begin
                imem_ack = 1'b0;
                busy     = 1'b0;
            end
        end
    end

    // Monitor: pops the expected stream on every consumed instruction.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        logic [31:0] e;
        prev_hold  = 1'b0;
        prev_instr = 32'h0;
        prev_pc    = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_hold) begin
                chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                chk("stall_instr", instr, prev_instr);
                chk("stall_pc", pc_out, prev_pc);
            end
            if (!rst && instr_valid && !stall && !redirect) begin
                deliveries++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got delivery pc %h expected none", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", pc_out, e);
                    chk("sb_instr", instr, mem_fn(e));
                    chk("sb_pc_plus4", pc_plus4, e + 32'd4);
                end
            end
            prev_hold  = !rst && instr_valid && stall && !redirect;
            prev_instr = instr;
            prev_pc    = pc_out;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] tgt;
        int          held_cnt;
        logic        got;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        load_stream(RESET_PC);

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc_out", pc_out, RESET_PC);
        chk("rst_instr", instr, 32'h0);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
`endif

        // Same-cycle ack throughput: one instruction every 2 cycles
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("tput_valid", {31'd0, instr_valid}, {31'd0, (i >= 2 && i % 2 == 0)});
            if (i % 2 == 1) begin
                chk("tput_req_ack", {31'd0, imem_req && imem_ack}, 32'd1);
                chk("tput_addr", imem_addr, RESET_PC + 32'(4 * (i / 2)));
            end
        end

        // Stall holds the presented instruction
        @(posedge clk); #1;
        stall = 1'b1;
        do_redirect(32'h0040_0010);
        wait_valid("stall_wait", 10);
        chk("stall_pc0", pc_out, 32'h0040_0010);
        chk("stall_instr0", instr, 32'h2008_0005);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
            chk("stall_pc_k", pc_out, 32'h0040_0010);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("release_req", {31'd0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'h0040_0014);
        chk("release_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect while a slow request is outstanding
        reset_dut();
        ack_min = 3;
        ack_max = 3;
        @(posedge clk); #1;
        do_redirect(32'h0040_0100);
        got      = 1'b0;
        held_cnt = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            chk("disc_novalid", {31'd0, instr_valid}, 32'd0);
            if (imem_req && imem_addr == RESET_PC) held_cnt++;
            else if (imem_req) begin
                got = 1'b1;
                chk("disc_next_addr", imem_addr, 32'h0040_0100);
            end
        end
        chk("disc_seen", {31'd0, got}, 32'd1);
        chk("disc_held_cycles", 32'(held_cnt), 32'd3);
        wait_valid("disc_deliver", 12);
        chk("disc_pc", pc_out, 32'h0040_0100);

        // PC wrap
        ack_min = 0;
        ack_max = 0;
        @(posedge clk); #1;
        do_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_wait0", 10);
        chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        chk("wrap_plus4_0", pc_plus4, 32'h0000_0000);
        wait_valid("wrap_wait1", 10);
        chk("wrap_pc1", pc_out, 32'h0000_0000);
        chk("wrap_plus4_1", pc_plus4, 32'h0000_0004);

        // Misaligned redirect target
        @(posedge clk); #1;
        do_redirect(32'h0040_0102);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("align_err", {31'd0, fetch_err}, 32'd1);
            chk("align_noreq", {31'd0, imem_req}, 32'd0);
            chk("align_novalid", {31'd0, instr_valid}, 32'd0);
        end
        @(posedge clk); #1;
        reset_dut();
        @(negedge clk);
        chk("align_err_clr", {31'd0, fetch_err}, 32'd0);
`else
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (imem_req) begin
                got = 1'b1;
                chk("align_addr", imem_addr, 32'h0040_0100);
            end
        end
        chk("align_seen", {31'd0, got}, 32'd1);
`endif

        // Reset while a request is pending
        @(posedge clk); #1;
        do_redirect(32'h0040_0200);
        wait_valid("rstreq_wait", 10);
        chk("rstreq_pc", pc_out, 32'h0040_0200);
        @(posedge clk); #1;
        ack_min = 3;
        ack_max = 3;
        @(posedge clk); #1;
        rst = 1'b1;
        load_stream(RESET_PC);
        @(negedge clk);
        chk("rstreq_req_in_rst", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_req", {31'd0, imem_req}, 32'd0);
        chk("rstreq_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstreq_pc_out", pc_out, RESET_PC);

        // Randomized traffic
        ack_min = 0;
        ack_max = 3;
        deliveries = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            redirect = 1'b0;
            stall    = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 6) begin
                tgt = 32'h0040_0000 + (32'($urandom_range(255)) << 2);
`ifndef MIPS_FETCH_ALIGN_CHECK_EN
                tgt[1:0] = 2'($urandom_range(3));
`endif
                redirect    = 1'b1;
                redirect_pc = tgt;
                load_stream(tgt & 32'hFFFF_FFFC);
            end
        end
        @(posedge clk); #1;
        redirect = 1'b0;
        stall    = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rand_deliveries", {31'd0, deliveries >= 60}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
